spi_master_arb: RTL and testbench
=================================

Name: spi_master_arb

Overview:
- Master-side SPI sequencer that shares one SPI link (cs, mosi) among NUM_REQ requesters and drives the slave datapath.
- Round-robin arbitration selects a requester, latches its parallel word, and serializes it MSB-first on mosi with cs framed low.
- Runs on the same sclk as the slave, so the slave captures one bit per sclk cycle.

Parameters:
- NUM_REQ, 2, number of requesters (≥2)
- DATA_W, 8, frame width in bits; matches the slave data width
- GAP, 2, minimum cycles spent in the GAP state between frames (≥1)

Ports:
- sclk  input  1  system/SPI clock, all logic on posedge
- rst  input  1  reset; one clock; reset is asynchronous and active-high
- req  input  NUM_REQ  level request per requester; held until its done pulse
- wdata  input  NUM_REQ*DATA_W  requester i word at bits [i*DATA_W +: DATA_W]
- gnt  output  NUM_REQ  one-hot grant, held for the whole frame
- done  output  NUM_REQ  one-cycle pulse to the served requester at frame end
- busy  output  1  high from grant through end of GAP
- cs  output  1  active-low chip select to slave
- mosi  output  1  serial data, MSB first

Behaviour:
- Reset (async, immediate): cs=1, mosi=0, gnt=0, done=0, busy=0, state=IDLE, RR pointer=0 (requester 0 highest priority), bit counter=0.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - cs=1, mosi=0.
  - On the edge where any req is high: pick the first requester at or after the RR pointer (wrapping).
  - On that edge: latch its wdata into the shift register, set gnt one-hot, busy=1, cs=0, mosi=MSB, bit counter=DATA_W-1, go SHIFT.
- SHIFT:
  - Each edge shifts left; mosi shows bit DATA_W-1 down to 0, one bit per cycle, for exactly DATA_W cycles of cs low.
  - On the edge after the LSB cycle: cs=1, mosi=0, gnt=0, done[i]=1 for one cycle, RR pointer=i+1 mod NUM_REQ, go GAP.
- GAP:
  - cs=1 for GAP cycles, busy=1, then IDLE.
  - Back-to-back frames see cs high for GAP+1 cycles (GAP cycles plus the IDLE arbitration cycle).
- Latency: req high at edge k → cs low and MSB on mosi after edge k; LSB during cycle k+DATA_W-1; done pulse after edge k+DATA_W.
- Simultaneous requests: the RR pointer decides. A requester that is continuously asserted is served within NUM_REQ frames.
- wdata is sampled only at grant. Changes during SHIFT are ignored.
- req dropped mid-frame: the frame still completes and done still pulses.
- req of the granted requester still high at done: treated as a new request and arbitrated normally (loses to others under RR).
- Reset mid-frame: cs rises asynchronously, the frame is aborted, no done pulse. After release, pending req restart from IDLE with full frames.
- Bit counter width: $clog2(DATA_W). RR pointer width: $clog2(NUM_REQ).
- Outputs are registered (no combinational path from req to cs/mosi).

Decomposition:
- Package spi_pkg: state typedef enum {IDLE, SHIFT, GAP}, shared localparam DATA_W default, bit-counter width function/localparam.
- One sub-module, spi_rr_arbiter: req and pointer in → one-hot grant plus valid out, purely combinational. The FSM registers its result.

Test Plan:
- Reset: hold rst=1 for 20 ns with req=2'b11 → cs=1, mosi=0, gnt=0, done=0, busy=0 throughout.
- Single frame: req[0]=1, wdata0=8'hA5 → cs low exactly 8 cycles, mosi 1,0,1,0,0,1,0,1; done[0] pulses once; slave data reads 8'hA5.
- Contention: req=2'b11 from reset, wdata0=8'h3C, wdata1=8'hC3 → frame 8'h3C (gnt=01), then 3 cs-high cycles (GAP=2), then 8'hC3 (gnt=10).
- Fairness: both req held for 6 frames → grant order 0,1,0,1,0,1; never two consecutive grants to one requester.
- Reset mid-frame: assert rst after 4 bits of 8'hFF → cs=1 within the same cycle, no done. After release with req[0] held → a full new 8-bit frame.
- Request withdrawal: drop req[1] at bit 3 of its frame → all 8 bits sent, done[1] pulses, then IDLE with busy=0 after GAP.

Source files
------------

// File: rtl/spi_master_arb_pkg.sv
// Shared types and sizing helpers for the round-robin SPI master sequencer.
package spi_pkg;

  // Sequencer states: wait for a request, serialize a word, hold cs high between frames.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam int NUM_REQ_DEF = 2;
  localparam int DATA_W_DEF  = 8;
  localparam int GAP_DEF     = 2;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/spi_master_arb_if.sv
// Requester handshake plus the SPI link (cs, mosi) of the sequencer.
interface spi_master_arb_if #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] wdata;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        done;
  logic                      busy;
  logic                      cs;
  logic                      mosi;

  // The sequencer side.
  modport master (input req, input wdata, output gnt, output done, output busy, output cs, output mosi);
  // The requester/observer side.
  modport slave (output req, output wdata, input gnt, input done, input busy, input cs, input mosi);
endinterface

// File: rtl/spi_master_arb_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module spi_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic               valid
);

  // Scan requesters starting at the pointer; the first asserted one wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    gnt   = '0;
    valid = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = PTR_W'((int'(ptr) + i) % NUM_REQ);
      if (!valid && req[idx]) begin
        gnt[idx] = 1'b1;
        valid    = 1'b1;
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/spi_master_arb.sv
// Round-robin SPI master: grants one requester, shifts its word MSB-first on
// mosi with cs low, pulses done, then holds cs high for a gap before rearbitrating.
module spi_master_arb
  import spi_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int GAP     = GAP_DEF
) (
  input logic              sclk,
  input logic              rst,
  spi_master_arb_if.master bus
);

  localparam int CNT_W = cnt_width(DATA_W);
  localparam int PTR_W = cnt_width(NUM_REQ);
  localparam int GAP_W = cnt_width(GAP);

  state_t              state_r, state_s;
  logic [PTR_W-1:0]    ptr_r, ptr_s;
  logic [CNT_W-1:0]    cnt_r, cnt_s;
  logic [GAP_W-1:0]    gap_r, gap_s;
  logic [DATA_W-1:0]   shreg_r, shreg_s;
  logic [NUM_REQ-1:0]  gnt_r, gnt_s;
  logic [NUM_REQ-1:0]  done_r, done_s;
  logic                busy_r, busy_s;
  logic                cs_r, cs_s;
  logic                mosi_r, mosi_s;

  logic [NUM_REQ-1:0]  arb_gnt;
  logic                arb_valid;
  logic [DATA_W-1:0]   sel_word_s;
  logic [PTR_W-1:0]    gnt_idx_s;

  spi_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .req   (bus.req),
    .ptr   (ptr_r),
    .gnt   (arb_gnt),
    .valid (arb_valid)
  );

  // Pick the word of the winning requester and encode the held grant as an index.
  always_comb begin
    sel_word_s = '0;
    gnt_idx_s  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) begin
        sel_word_s = bus.wdata[i*DATA_W +: DATA_W];
      end else begin
        sel_word_s = sel_word_s;
      end
      if (gnt_r[i]) begin
        gnt_idx_s = PTR_W'(i);
      end else begin
        gnt_idx_s = gnt_idx_s;
      end
    end
  end

  // Next-state and next-output logic of the frame sequencer.
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    cnt_s   = cnt_r;
    gap_s   = gap_r;
    shreg_s = shreg_r;
    gnt_s   = gnt_r;
    done_s  = '0;
    busy_s  = busy_r;
    cs_s    = cs_r;
    mosi_s  = mosi_r;
    case (state_r)
      ST_IDLE: begin
        cs_s   = 1'b1;
        mosi_s = 1'b0;
        if (arb_valid) begin
          // MSB goes out now; the shift register keeps the remaining bits.
          shreg_s = sel_word_s << 1;
          mosi_s  = sel_word_s[DATA_W-1];
          cs_s    = 1'b0;
          gnt_s   = arb_gnt;
          busy_s  = 1'b1;
          cnt_s   = CNT_W'(DATA_W - 1);
          state_s = ST_SHIFT;
        end else begin
          gnt_s  = '0;
          busy_s = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (cnt_r == '0) begin
          // LSB cycle is over: close the frame and move priority past the winner.
          cs_s    = 1'b1;
          mosi_s  = 1'b0;
          gnt_s   = '0;
          done_s  = gnt_r;
          ptr_s   = (gnt_idx_s == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx_s + PTR_W'(1);
          gap_s   = GAP_W'(GAP - 1);
          state_s = ST_GAP;
        end else begin
          mosi_s  = shreg_r[DATA_W-1];
          shreg_s = shreg_r << 1;
          cnt_s   = cnt_r - CNT_W'(1);
        end
      end
      ST_GAP: begin
        cs_s = 1'b1;
        if (gap_r == '0) begin
          busy_s  = 1'b0;
          state_s = ST_IDLE;
        end else begin
          gap_s = gap_r - GAP_W'(1);
        end
      end
      default: begin
        state_s = ST_IDLE;
        cs_s    = 1'b1;
        mosi_s  = 1'b0;
        gnt_s   = '0;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset forces cs high immediately and aborts any frame.
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      ptr_r   <= '0;
      cnt_r   <= '0;
      gap_r   <= '0;
      shreg_r <= '0;
      gnt_r   <= '0;
      done_r  <= '0;
      busy_r  <= 1'b0;
      cs_r    <= 1'b1;
      mosi_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      cnt_r   <= cnt_s;
      gap_r   <= gap_s;
      shreg_r <= shreg_s;
      gnt_r   <= gnt_s;
      done_r  <= done_s;
      busy_r  <= busy_s;
      cs_r    <= cs_s;
      mosi_r  <= mosi_s;
    end
  end

  assign bus.gnt  = gnt_r;
  assign bus.done = done_r;
  assign bus.busy = busy_r;
  assign bus.cs   = cs_r;
  assign bus.mosi = mosi_r;

endmodule

// File: tb/tb_spi_master_arb.sv
// Directed bench for spi_master_arb: reset, contention/fairness, single frame,
// request withdrawal and reset mid-frame, with a small capturing slave model.
module tb_spi_master_arb;

  localparam int NUM_REQ = 2;
  localparam int DATA_W  = 8;
  localparam int GAP     = 2;

  logic sclk;
  logic rst;
  logic [DATA_W-1:0] slave_sr;
  int n_cmp;
  int n_err;

  spi_master_arb_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

  spi_master_arb #(
    .NUM_REQ (NUM_REQ),
    .DATA_W  (DATA_W),
    .GAP     (GAP)
  ) dut (
    .sclk (sclk),
    .rst  (rst),
    .bus  (bus)
  );

  // 10 ns system clock.
  initial begin
    sclk = 1'b0;
    forever #5 sclk = ~sclk;
  end

  // Slave model: captures mosi on every rising edge while cs is low.
  always @(posedge sclk) begin
    if (!bus.cs) begin
      slave_sr <= {slave_sr[DATA_W-2:0], bus.mosi};
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at the falling edge just before the grant edge; checks the full frame
  // and the done cycle. Optionally drops req bits after bit drop_at and releases
  // the served request once done is seen.
  task automatic frame(input string tag, input logic [DATA_W-1:0] word,
                       input logic [NUM_REQ-1:0] g, input int drop_at,
                       input logic [NUM_REQ-1:0] drop_mask, input bit release_req);
    for (int n = 0; n < DATA_W; n++) begin
      @(negedge sclk);
      check({tag, "_cs"},   32'(bus.cs),   32'd0);
      check({tag, "_mosi"}, 32'(bus.mosi), 32'(word[DATA_W-1-n]));
      check({tag, "_gnt"},  32'(bus.gnt),  32'(g));
      check({tag, "_busy"}, 32'(bus.busy), 32'd1);
      check({tag, "_done0"}, 32'(bus.done), 32'd0);
      if (n == drop_at) bus.req = bus.req & ~drop_mask;
    end
    @(negedge sclk);
    check({tag, "_cs_end"},   32'(bus.cs),   32'd1);
    check({tag, "_mosi_end"}, 32'(bus.mosi), 32'd0);
    check({tag, "_gnt_end"},  32'(bus.gnt),  32'd0);
    check({tag, "_done"},     32'(bus.done), 32'(g));
    check({tag, "_busy_end"}, 32'(bus.busy), 32'd1);
    check({tag, "_slave"},    32'(slave_sr), 32'(word));
    if (release_req) bus.req = bus.req & ~g;
  endtask

  // Rest of the gap after the done cycle, ending at the idle arbitration cycle.
  task automatic gap_check(input string tag);
    for (int n = 0; n < GAP - 1; n++) begin
      @(negedge sclk);
      check({tag, "_gap_cs"},   32'(bus.cs),   32'd1);
      check({tag, "_gap_busy"}, 32'(bus.busy), 32'd1);
      check({tag, "_gap_done"}, 32'(bus.done), 32'd0);
    end
    @(negedge sclk);
    check({tag, "_idle_cs"},   32'(bus.cs),   32'd1);
    check({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_idle_gnt"},  32'(bus.gnt),  32'd0);
  endtask

  initial begin
    logic [DATA_W-1:0] w;
    logic [NUM_REQ-1:0] g;
    n_cmp    = 0;
    n_err    = 0;
    slave_sr = '0;
    rst      = 1'b1;
    bus.req  = 2'b11;
    bus.wdata = {8'hC3, 8'h3C};

    // Reset held for 20 ns with both requests pending: link must stay idle.
    for (int n = 0; n < 2; n++) begin
      @(negedge sclk);
      check("rst_cs",   32'(bus.cs),   32'd1);
      check("rst_mosi", 32'(bus.mosi), 32'd0);
      check("rst_gnt",  32'(bus.gnt),  32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
    end
    rst = 1'b0;

    // Contention then fairness: six frames alternating 0,1,0,1,0,1.
    for (int f = 0; f < 6; f++) begin
      g = (f % 2 == 0) ? 2'b01 : 2'b10;
      w = (f % 2 == 0) ? 8'h3C : 8'hC3;
      frame($sformatf("rr%0d", f), w, g, -1, 2'b00, 1'b0);
      gap_check($sformatf("rr%0d", f));
    end

    // Single frame from requester 0 (pointer back at 0).
    bus.req   = 2'b01;
    bus.wdata = {8'h00, 8'hA5};
    frame("single", 8'hA5, 2'b01, -1, 2'b00, 1'b1);
    gap_check("single");
    @(negedge sclk);
    check("single_stay_idle", 32'(bus.busy), 32'd0);

    // Withdrawal: requester 1 drops req after bit 3; frame still completes.
    bus.req   = 2'b10;
    bus.wdata = {8'h5A, 8'h00};
    frame("wdraw", 8'h5A, 2'b10, 3, 2'b10, 1'b0);
    gap_check("wdraw");
    @(negedge sclk);
    check("wdraw_stay_idle", 32'(bus.busy), 32'd0);
    check("wdraw_stay_cs",   32'(bus.cs),   32'd1);

    // Reset mid-frame after four bits of 8'hFF.
    bus.req   = 2'b01;
    bus.wdata = {8'h00, 8'hFF};
    for (int n = 0; n < 4; n++) begin
      @(negedge sclk);
      check("mid_cs",   32'(bus.cs),   32'd0);
      check("mid_mosi", 32'(bus.mosi), 32'd1);
    end
    rst = 1'b1;
    #1;
    check("mid_rst_cs",   32'(bus.cs),   32'd1);
    check("mid_rst_mosi", 32'(bus.mosi), 32'd0);
    check("mid_rst_gnt",  32'(bus.gnt),  32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_done", 32'(bus.done), 32'd0);
    @(negedge sclk);
    check("mid_rst_done2", 32'(bus.done), 32'd0);
    check("mid_rst_cs2",   32'(bus.cs),   32'd1);
    rst = 1'b0;
    frame("restart", 8'hFF, 2'b01, -1, 2'b00, 1'b1);
    gap_check("restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
